// File: rtl/clock_pkg.sv
// Shared types, BCD limits and helpers for the multi-alarm clock core.
package clock_pkg;

    typedef enum logic [1:0] {
        CH_IDLE    = 2'd0,
        CH_RINGING = 2'd1,
        CH_SNOOZED = 2'd2
    } ch_state_t;

    localparam logic [7:0] BCD_HH_MAX = 8'h23;
    localparam logic [7:0] BCD_MS_MAX = 8'h59;

    // Both nibbles must be decimal digits.
    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Two-digit BCD increment with wrap at max; returns {carry, next}.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return {1'b1, 8'h00};
        else if (v[3:0] == 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    // Internal 00..23 hour to 12-hour display 01..12 (00 shows as 12).
    function automatic logic [7:0] bcd_to_12h(input logic [7:0] hh);
        logic [4:0] bin;
        logic [4:0] h12;
        bin = 5'(hh[7:4]) * 5'd10 + 5'(hh[3:0]);
        if (bin == 5'd0)
            h12 = 5'd12;
        else if (bin > 5'd12)
            h12 = bin - 5'd12;
        else
            h12 = bin;
        return (h12 >= 5'd10) ? {4'd1, 4'(h12 - 5'd10)} : {4'd0, h12[3:0]};
    endfunction

endpackage

// File: rtl/bcd_alarm_channel.sv
// One alarm channel: HH:MM register, ring/snooze state machine and its counters.
module bcd_alarm_channel
    import clock_pkg::*;
#(
    parameter int unsigned RING_SECS  = 60,
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic       ld_we,
    input  logic [7:0] ld_hh,
    input  logic [7:0] ld_mm,
    input  logic       en,
    input  logic       ack,
    input  logic       snooze,
    input  logic [7:0] time_hh,
    input  logic [7:0] time_mm,
    input  logic [7:0] time_ss,
    output logic       ring
);

    localparam int unsigned SNOOZE_TICKS = SNOOZE_MIN * 60;
    localparam int unsigned RW = $clog2(RING_SECS + 1);
    localparam int unsigned SW = $clog2(SNOOZE_TICKS + 1);

    ch_state_t     state;
    logic [7:0]    al_hh;
    logic [7:0]    al_mm;
    logic [RW-1:0] ring_cnt;
    logic [SW-1:0] snz_cnt;
    logic          match_c;

    // time_* carries the value the clock is advancing to on this tick
    assign match_c = tick && en && (time_hh == al_hh) && (time_mm == al_mm) && (time_ss == 8'h00);

    // Alarm time register, written only by the load port.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            al_hh <= 8'h00;
            al_mm <= 8'h00;
        end else if (ld_we) begin
            al_hh <= ld_hh;
            al_mm <= ld_mm;
        end
    end

    // Channel state machine; ring is registered alongside the state.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state    <= CH_IDLE;
            ring     <= 1'b0;
            ring_cnt <= '0;
            snz_cnt  <= '0;
        end else begin
            case (state)
                CH_IDLE: begin
                    if (match_c) begin
                        state    <= CH_RINGING;
                        ring     <= 1'b1;
                        ring_cnt <= '0;
                    end
                end
                CH_RINGING: begin
                    if (ack || !en) begin
                        state <= CH_IDLE;
                        ring  <= 1'b0;
                    end else if (snooze) begin
                        state   <= CH_SNOOZED;
                        ring    <= 1'b0;
                        snz_cnt <= SW'(SNOOZE_TICKS);
                    end else if (tick) begin
                        if (ring_cnt == RW'(RING_SECS - 1)) begin
                            state <= CH_IDLE;
                            ring  <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt + 1'b1;
                        end
                    end
                end
                CH_SNOOZED: begin
                    if (ack || !en) begin
                        state <= CH_IDLE;
                    end else if (tick) begin
                        if (snz_cnt == SW'(1)) begin
                            state    <= CH_RINGING;
                            ring     <= 1'b1;
                            ring_cnt <= '0;
                        end else begin
                            snz_cnt <= snz_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= CH_IDLE;
                    ring  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bcd_multi_alarm_clock.sv
// BCD time-of-day clock with tick divider, load port and NUM_ALARMS alarm channels.
module bcd_multi_alarm_clock
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned NUM_ALARMS = 2,
    parameter int unsigned RING_SECS  = 60,
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              ld_valid,
    input  logic [$clog2(NUM_ALARMS+1)-1:0]   ld_target,
    input  logic [7:0]                        ld_hh,
    input  logic [7:0]                        ld_mm,
    input  logic [7:0]                        ld_ss,
    input  logic                              mode_12h,
    input  logic [NUM_ALARMS-1:0]             alarm_en,
    input  logic [NUM_ALARMS-1:0]             ack,
    input  logic [NUM_ALARMS-1:0]             snooze,
    output logic [7:0]                        hh_disp,
    output logic [7:0]                        mm,
    output logic [7:0]                        ss,
    output logic                              pm,
    output logic                              tick,
    output logic [NUM_ALARMS-1:0]             ring,
    output logic                              ld_err
);

    localparam int unsigned DW = $clog2(TICK_DIV);
    localparam int unsigned TW = $clog2(NUM_ALARMS + 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_next_c;
    logic [7:0]    hh_q;
    logic          tick_now_c;
    logic          fields_ok_c;
    logic          ld_ok_c;
    logic          time_ld_c;
    logic          adv_c;
    logic [8:0]    ss_inc_c;
    logic [8:0]    mm_inc_c;
    logic [8:0]    hh_inc_c;
    logic [7:0]    hh_nx_c;
    logic [7:0]    mm_nx_c;
    logic [7:0]    ss_nx_c;

    assign tick_now_c = (div_q == DW'(TICK_DIV - 1));

    // Load validation, next time value and next divider value.
    always_comb begin
        fields_ok_c = bcd_valid(ld_hh) && bcd_valid(ld_mm) &&
                      (ld_hh <= BCD_HH_MAX) && (ld_mm <= BCD_MS_MAX);
        if (ld_target == '0)
            fields_ok_c = fields_ok_c && bcd_valid(ld_ss) && (ld_ss <= BCD_MS_MAX);
        ld_ok_c   = fields_ok_c && (ld_target <= TW'(NUM_ALARMS));
        time_ld_c = ld_valid && ld_ok_c && (ld_target == '0);
        // a time load on the tick edge swallows that tick
        adv_c     = tick_now_c && !time_ld_c;

        ss_inc_c = bcd_inc(ss, BCD_MS_MAX);
        mm_inc_c = bcd_inc(mm, BCD_MS_MAX);
        hh_inc_c = bcd_inc(hh_q, BCD_HH_MAX);

        hh_nx_c = hh_q;
        mm_nx_c = mm;
        ss_nx_c = ss;
        if (time_ld_c) begin
            hh_nx_c = ld_hh;
            mm_nx_c = ld_mm;
            ss_nx_c = ld_ss;
        end else if (adv_c) begin
            ss_nx_c = ss_inc_c[7:0];
            if (ss_inc_c[8]) begin
                mm_nx_c = mm_inc_c[7:0];
                if (mm_inc_c[8])
                    hh_nx_c = hh_inc_c[7:0];
            end
        end

        if (time_ld_c || tick_now_c)
            div_next_c = '0;
        else
            div_next_c = div_q + 1'b1;
    end

    // Divider, time registers and registered tick / ld_err pulses.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            div_q  <= '0;
            tick   <= 1'b0;
            hh_q   <= 8'h00;
            mm     <= 8'h00;
            ss     <= 8'h00;
            ld_err <= 1'b0;
        end else begin
            div_q  <= div_next_c;
            tick   <= (div_next_c == DW'(TICK_DIV - 1));
            hh_q   <= hh_nx_c;
            mm     <= mm_nx_c;
            ss     <= ss_nx_c;
            ld_err <= ld_valid && !ld_ok_c;
        end
    end

    assign hh_disp = mode_12h ? bcd_to_12h(hh_q) : hh_q;
    assign pm      = (hh_q >= 8'h12);

    // One channel per alarm; channels see the post-tick time for matching.
    for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_ch
        bcd_alarm_channel #(
            .RING_SECS  (RING_SECS),
            .SNOOZE_MIN (SNOOZE_MIN)
        ) u_ch (
            .clk     (clk),
            .resetn  (resetn),
            .tick    (adv_c),
            .ld_we   (ld_valid && ld_ok_c && (ld_target == TW'(k + 1))),
            .ld_hh   (ld_hh),
            .ld_mm   (ld_mm),
            .en      (alarm_en[k]),
            .ack     (ack[k]),
            .snooze  (snooze[k]),
            .time_hh (hh_nx_c),
            .time_mm (mm_nx_c),
            .time_ss (ss_nx_c),
            .ring    (ring[k])
        );
    end

endmodule

// File: tb/tb_bcd_multi_alarm_clock.sv
// Scoreboard bench for bcd_multi_alarm_clock against a seconds-based reference model.
module tb_bcd_multi_alarm_clock;

    localparam int TD = 4;
    localparam int NA = 2;
    localparam int RS = 3;
    localparam int SM = 1;
    localparam int S_IDLE = 0, S_RING = 1, S_SNZ = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          ld_valid = 1'b0;
    logic [1:0]    ld_target = 2'd0;
    logic [7:0]    ld_hh = 8'h00, ld_mm = 8'h00, ld_ss = 8'h00;
    logic          mode_12h = 1'b0;
    logic [NA-1:0] alarm_en = '0, ack = '0, snooze = '0;
    logic [7:0]    hh_disp, mm, ss;
    logic          pm, tick, ld_err;
    logic [NA-1:0] ring;

    bcd_multi_alarm_clock #(
        .TICK_DIV(TD), .NUM_ALARMS(NA), .RING_SECS(RS), .SNOOZE_MIN(SM)
    ) dut (
        .clk(clk), .resetn(resetn), .ld_valid(ld_valid), .ld_target(ld_target),
        .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss), .mode_12h(mode_12h),
        .alarm_en(alarm_en), .ack(ack), .snooze(snooze),
        .hh_disp(hh_disp), .mm(mm), .ss(ss), .pm(pm), .tick(tick),
        .ring(ring), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            tod;
        logic [NA-1:0] ring;
    } snap_t;

    snap_t exp_q[$];
    int    err_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // reference model: time as seconds of day, alarms as minute of day
    int m_tod, m_div;
    int m_alarm[NA];
    int m_st[NA];
    int m_rleft[NA];
    int m_sleft[NA];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit nib_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int h12(input int h);
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    function automatic logic [NA-1:0] model_ring();
        logic [NA-1:0] r;
        for (int k = 0; k < NA; k++) r[k] = (m_st[k] == S_RING);
        return r;
    endfunction

    task automatic model_reset();
        m_tod = 0;
        m_div = 0;
        for (int k = 0; k < NA; k++) begin
            m_alarm[k] = 0; m_st[k] = S_IDLE; m_rleft[k] = 0; m_sleft[k] = 0;
        end
        exp_q.delete();
        err_q.delete();
    endtask

    // Predict the effect of the upcoming clock edge given the driven inputs.
    task automatic model_edge();
        bit ok, tl, tk, et;
        int t, h, m, s;
        snap_t sn;
        t  = int'(ld_target);
        h  = bcd2int(ld_hh);
        m  = bcd2int(ld_mm);
        s  = bcd2int(ld_ss);
        ok = nib_ok(ld_hh) && nib_ok(ld_mm) && h < 24 && m < 60 && t <= NA;
        if (t == 0) ok = ok && nib_ok(ld_ss) && s < 60;
        tl = ld_valid && ok && t == 0;
        tk = (m_div == TD - 1);
        et = tk && !tl;
        m_div = (tl || tk) ? 0 : m_div + 1;
        if (tl) m_tod = h * 3600 + m * 60 + s;
        else if (et) m_tod = (m_tod + 1) % 86400;
        for (int k = 0; k < NA; k++) begin
            case (m_st[k])
                S_IDLE: if (et && alarm_en[k] && (m_tod % 60) == 0 && (m_tod / 60) == m_alarm[k]) begin
                    m_st[k] = S_RING; m_rleft[k] = RS;
                end
                S_RING: if (ack[k] || !alarm_en[k]) m_st[k] = S_IDLE;
                    else if (snooze[k]) begin m_st[k] = S_SNZ; m_sleft[k] = SM * 60; end
                    else if (et) begin
                        m_rleft[k]--;
                        if (m_rleft[k] == 0) m_st[k] = S_IDLE;
                    end
                default: if (ack[k] || !alarm_en[k]) m_st[k] = S_IDLE;
                    else if (et) begin
                        m_sleft[k]--;
                        if (m_sleft[k] == 0) begin m_st[k] = S_RING; m_rleft[k] = RS; end
                    end
            endcase
        end
        if (ld_valid && ok && t >= 1) m_alarm[t-1] = h * 60 + m;
        if (ld_valid && !ok) begin
            check("ld_err_backlog", int'(err_q.size() > 1), 0);
            err_q.push_back(1);
        end
        if (m_div == TD - 1) begin
            check("tick_backlog", int'(exp_q.size() > 1), 0);
            sn.tod  = m_tod;
            sn.ring = model_ring();
            exp_q.push_back(sn);
        end
    endtask

    // One clock: model the edge, let it happen, then drop single-cycle pulses.
    task automatic clk_step();
        model_edge();
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ack      = '0;
        snooze   = '0;
    endtask

    task automatic run(input int n);
        repeat (n) clk_step();
    endtask

    task automatic load(input int tgt, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        ld_valid = 1'b1; ld_target = 2'(tgt); ld_hh = h; ld_mm = m; ld_ss = s;
        clk_step();
    endtask

    // Monitor: whenever the DUT shows tick or ld_err, pop and compare.
    initial begin
        snap_t sn;
        int    hr;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                if (tick) begin
                    if (exp_q.size() == 0) begin
                        check("tick_unexpected", 1, 0);
                    end else begin
                        sn = exp_q.pop_front();
                        hr = sn.tod / 3600;
                        check("hh_disp", int'(hh_disp), int'(int2bcd(mode_12h ? h12(hr) : hr)));
                        check("mm", int'(mm), int'(int2bcd((sn.tod / 60) % 60)));
                        check("ss", int'(ss), int'(int2bcd(sn.tod % 60)));
                        check("pm", int'(pm), int'(hr >= 12));
                        check("ring", int'(ring), int'(sn.ring));
                    end
                end
                if (ld_err) begin
                    check("ld_err_expected", int'(err_q.size() > 0), 1);
                    if (err_q.size() > 0) void'(err_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_tick", int'(tick), 0);
        check("rst_ring", int'(ring), 0);
        check("rst_ld_err", int'(ld_err), 0);
        check("rst_pm", int'(pm), 0);
        check("rst_hh", int'(hh_disp), 8'h00);
        check("rst_mm", int'(mm), 8'h00);
        check("rst_ss", int'(ss), 8'h00);
        mode_12h = 1'b1;
        #1;
        check("rst_hh_12h", int'(hh_disp), 8'h12);
        mode_12h = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        model_reset();

        // midnight rollover
        run(2);
        load(0, 8'h23, 8'h59, 8'h58);
        run(3 * TD);

        // alarm 0 fires at 07:30:00
        alarm_en = 2'b01;
        load(1, 8'h07, 8'h30, 8'h00);
        load(0, 8'h07, 8'h29, 8'h59);
        run(2 * TD);

        // snooze, re-ring after a minute, then ack; ack+snooze together
        snooze = 2'b01;
        clk_step();
        run(62 * TD);
        ack = 2'b01; snooze = 2'b01;
        clk_step();
        run(2 * TD);

        // unacknowledged ring self-clears; ack in idle ignored
        load(0, 8'h07, 8'h29, 8'h59);
        run(6 * TD);
        ack = 2'b11;
        clk_step();
        run(2 * TD);

        // rejected loads
        load(0, 8'h24, 8'h00, 8'h00);
        run(2);
        load(0, 8'h10, 8'h5A, 8'h00);
        run(2);
        load(3, 8'h10, 8'h10, 8'h00);
        run(2);
        load(0, 8'h10, 8'h10, 8'h0A);
        load(2, 8'h1A, 8'h00, 8'h00);
        run(2 * TD);

        // load coincident with tick
        while (m_div != TD - 1) clk_step();
        load(0, 8'h05, 8'h06, 8'h07);
        run(2 * TD);

        // 12-hour mapping
        mode_12h = 1'b1;
        load(0, 8'h00, 8'h00, 8'h00); run(TD + 1);
        load(0, 8'h12, 8'h00, 8'h00); run(TD + 1);
        load(0, 8'h13, 8'h00, 8'h00); run(TD + 1);
        load(0, 8'h23, 8'h00, 8'h00); run(TD + 1);

        // randomized traffic around a 12:00 alarm on both channels
        alarm_en = 2'b11;
        load(1, 8'h12, 8'h00, 8'h00);
        load(2, 8'h12, 8'h00, 8'h00);
        for (int i = 0; i < 600; i++) begin
            mode_12h = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                ld_valid = 1'b1;
                if ($urandom_range(0, 1) == 0) begin
                    ld_target = 2'd0; ld_hh = 8'h11; ld_mm = 8'h59;
                    ld_ss = int2bcd(int'($urandom_range(55, 59)));
                end else begin
                    ld_target = 2'($urandom);
                    ld_hh = ($urandom_range(0, 2) != 0) ? int2bcd(int'($urandom_range(0, 23))) : 8'($urandom);
                    ld_mm = ($urandom_range(0, 2) != 0) ? int2bcd(int'($urandom_range(0, 59))) : 8'($urandom);
                    ld_ss = ($urandom_range(0, 2) != 0) ? int2bcd(int'($urandom_range(0, 59))) : 8'($urandom);
                end
            end
            for (int k = 0; k < NA; k++) begin
                if ($urandom_range(0, 40) == 0) ack[k] = 1'b1;
                if ($urandom_range(0, 30) == 0) snooze[k] = 1'b1;
                if ($urandom_range(0, 120) == 0) alarm_en[k] = ~alarm_en[k];
            end
            clk_step();
        end

        // both channels ringing, then asynchronous reset mid-cycle
        mode_12h = 1'b0;
        alarm_en = 2'b11;
        load(1, 8'h10, 8'h00, 8'h00);
        load(2, 8'h10, 8'h00, 8'h00);
        load(0, 8'h09, 8'h59, 8'h59);
        run(TD + 1);
        @(negedge clk);
        check("ring_both", int'(ring), int'(model_ring()));
        check("ring_both_on", int'(model_ring()), 3);
        #2;
        resetn = 1'b1;
        ld_valid = 1'b1; ld_target = 2'd0; ld_hh = 8'h01; ld_mm = 8'h02; ld_ss = 8'h03;
        #1;
        check("arst_ring", int'(ring), 0);
        check("arst_tick", int'(tick), 0);
        check("arst_hh", int'(hh_disp), 8'h00);
        check("arst_mm", int'(mm), 8'h00);
        check("arst_ss", int'(ss), 8'h00);
        check("arst_pm", int'(pm), 0);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        resetn = 1'b0;
        model_reset();
        run(3 * TD);

        @(negedge clk);
        #1;
        check("tick_queue_drained", exp_q.size(), 0);
        check("err_queue_drained", err_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_multi_alarm_clock.md
Name: bcd_multi_alarm_clock

Overview:
Parametrised successor to the single-alarm clock core: a BCD time-of-day counter (HH:MM:SS) driven from a configurable tick divider, with NUM_ALARMS independent alarm channels. Each channel has enable, ring, acknowledge and snooze behaviour. The block sits between the board-level switch/key decode and the 7-segment/LED drivers. It exposes a single load port for setting the time or any alarm, plus 12/24-hour display mode.

Parameters:
TICK_DIV, 50000000, clk cycles per 1 s tick (minimum 2)
NUM_ALARMS, 2, number of alarm channels (1..8)
RING_SECS, 60, seconds an unacknowledged alarm rings before self-clearing
SNOOZE_MIN, 5, snooze duration in minutes (1..59)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous, active-high reset (asserted = 1 despite the name)
ld_valid  in  1  single-cycle load strobe
ld_target  in  $clog2(NUM_ALARMS+1)  0 = time of day; k = alarm k-1
ld_hh  in  8  BCD hours 00..23
ld_mm  in  8  BCD minutes 00..59
ld_ss  in  8  BCD seconds 00..59 (ignored for alarm targets)
mode_12h  in  1  1 = 12-hour display outputs
alarm_en  in  NUM_ALARMS  per-channel enable
ack  in  NUM_ALARMS  per-channel stop pulse
snooze  in  NUM_ALARMS  per-channel snooze pulse
hh_disp  out  8  BCD displayed hours (01..12 in 12h mode, 00..23 otherwise)
mm  out  8  BCD minutes
ss  out  8  BCD seconds
pm  out  1  1 when internal hour ≥ 12 (valid in both modes)
tick  out  1  one-cycle pulse per second
ring  out  NUM_ALARMS  per-channel ringing
ld_err  out  1  one-cycle pulse: load rejected

Behaviour:
- Reset: time = 00:00:00, divider = 0, all alarm registers = 00:00, all channels IDLE. Outputs: tick, ring, ld_err, pm = 0; hh_disp = 00 (12 in 12h mode, combinational from internal hour).
- Divider: counts 0..TICK_DIV-1. tick is asserted in the cycle the divider equals TICK_DIV-1; the divider then wraps to 0.
- On tick, the time advances by 1 s. Carries: ss 59→00 increments mm; mm 59→00 increments hh; hh 23→00. Each BCD digit is kept separately, low nibble 9→0 carries to the high nibble.
- Load: ld_valid is sampled on a clk edge. A load is rejected (ld_err pulses the next cycle, no state change) if any nibble > 9, hh > 23, mm > 59, ss > 59, or ld_target > NUM_ALARMS.
- A valid time load updates the time registers on that edge and clears the divider to 0. If ld_valid and tick coincide, the load wins and the tick is lost.
- A valid alarm load writes HH:MM only. It does not change that channel's state.
- 12h mapping: internal 00→12, 01..12→same, 13..23→hh-12. Purely combinational.
- Channel FSM (per channel), match = alarm_en & (time HH:MM == alarm HH:MM) & ss == 00, evaluated on tick:
  IDLE → RINGING on match; ring = 1 from the cycle after the matching tick.
  RINGING → IDLE on ack, on alarm_en = 0, or after RING_SECS ticks.
  RINGING → SNOOZED on snooze; the channel loads a seconds countdown of SNOOZE_MIN*60.
  SNOOZED → RINGING when the countdown reaches 0 (decremented on tick).
  SNOOZED → IDLE on ack or alarm_en = 0.
- Pulses: ack or snooze in IDLE is ignored. ack and snooze in the same cycle: ack wins.
- Time reload while SNOOZED: the countdown continues unaffected. A match can still fire only from IDLE.
- Channels are fully independent; several may ring at once.
- Reset mid-operation forces every register to its reset value immediately (asynchronous); no pending load survives.

Decomposition:
- Shared package clock_pkg holds:
  - channel state enum (IDLE, RINGING, SNOOZED)
  - BCD limit constants (8'h23, 8'h59)
  - a bcd_valid function
  - the 12h conversion function
- Sub-module bcd_alarm_channel: alarm register, FSM, ring and snooze counters. Instantiated NUM_ALARMS times by a generate loop.
- The top level holds the divider, time counter, load decode and output mapping.

Test Plan:
1. TICK_DIV=4; reset; load time 23:59:58; run 2 ticks → 00:00:00, pm = 0, tick every 4 cycles, divider restarts at load.
2. Load alarm 0 = 07:30 with alarm_en[0] = 1; time 07:29:59; one tick → ring[0] = 1 at 07:30:00; ring[1] = 0.
3. Ringing channel 0, snooze pulse with SNOOZE_MIN=1 → ring[0] = 0; exactly 60 ticks later ring[0] = 1; then ack → ring[0] = 0, back to IDLE.
4. RING_SECS=3, no ack → ring[0] clears after the 3rd tick; ack pulses in IDLE have no effect.
5. Load hh = 8'h24, then mm = 8'h5A, then ld_target = NUM_ALARMS+1 → ld_err pulses each time, state unchanged. ld_valid coincident with tick → loaded value held, no increment.
6. mode_12h = 1 at internal 00, 12, 13, 23 → hh_disp 12/12/01/11, pm 0/1/1/1. Assert resetn while two channels ring → all outputs return to reset values immediately.
